// File: rtl/cardinal_nic_if.sv
// cardinal_nic_if: bundles the CPU NIC port and the router port of cardinal_nic.
//   master : environment side (CPU + router) that drives requests and packets in
//   slave  : the NIC itself
// CPU side    : addr[0:1], d_in[0:63], d_out[0:63], nicEn, nicWrEn
// Router side : net_so, net_ro, net_do[0:63], net_si, net_ri, net_di[0:63], net_polarity
// All data vectors are big-endian numbered: bit 0 is the MSB.
interface cardinal_nic_if;
   logic [0:1]  addr;
   logic [0:63] d_in;
   logic [0:63] d_out;
   logic        nicEn;
   logic        nicWrEn;
   logic        net_so;
   logic        net_ro;
   logic [0:63] net_do;
   logic        net_si;
   logic        net_ri;
   logic [0:63] net_di;
   logic        net_polarity;

   modport master (
      output addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      input  d_out, net_so, net_do, net_ri
   );

   modport slave (
      input  addr, d_in, nicEn, nicWrEn, net_ro, net_si, net_di, net_polarity,
      output d_out, net_so, net_do, net_ri
   );
endinterface

// File: rtl/cardinal_nic.sv
// cardinal_nic: network interface between the cardinal CPU NIC port and a router port.
// Holds one 64-bit packet per direction and exposes four CPU registers:
//   00 in-buf (read clears in_full), 01 in-status, 10 out-buf (write), 11 out-status.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : cardinal_nic_if.slave (CPU request/read data and router send/ready handshakes)
// Optional feature: define NIC_DROP_CNT_EN to add a 16-bit saturating counter of
// writes dropped because out_buf was full, reported in out-status bits [32:47].
module cardinal_nic (
   input logic           clk,
   input logic           rst,
   cardinal_nic_if.slave bus
);

   logic [0:63] in_buf_q, in_buf_d;
   logic [0:63] out_buf_q, out_buf_d;
   logic [0:63] d_out_q, d_out_d;
   logic        in_full_q, in_full_d;
   logic        out_full_q, out_full_d;
   logic [15:0] drop_cnt;
   logic        rd_en;
   logic        wr_out;
   logic        accept_in;

   assign rd_en     = bus.nicEn & ~bus.nicWrEn;
   assign wr_out    = bus.nicEn & bus.nicWrEn & (bus.addr == 2'b10);
   assign accept_in = bus.net_si & ~in_full_q;

   // out_buf[0] is the VC bit; a packet may only leave on its matching polarity.
   assign bus.net_so = out_full_q & bus.net_ro & (bus.net_polarity == out_buf_q[0]);
   assign bus.net_ri = ~in_full_q;
   assign bus.net_do = out_buf_q;
   assign bus.d_out  = d_out_q;

`ifdef NIC_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else if (wr_out && out_full_q && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign drop_cnt = drop_cnt_q;
`else
   assign drop_cnt = '0;
`endif

   always_comb begin
      in_buf_d   = in_buf_q;
      in_full_d  = in_full_q;
      out_buf_d  = out_buf_q;
      out_full_d = out_full_q;
      d_out_d    = d_out_q;

      if (rd_en) begin
         d_out_d = '0;
         case (bus.addr)
            2'b00: begin
               d_out_d   = in_buf_q;
               in_full_d = 1'b0;
            end
            2'b01: d_out_d[63] = in_full_q;
            2'b11: begin
               d_out_d[63]    = out_full_q;
               d_out_d[32:47] = drop_cnt;
            end
            default: d_out_d = '0;
         endcase
      end

      // Ejection only happens when empty, so it never races a pending packet;
      // if an in-buf read coincides, the new packet must survive.
      if (accept_in) begin
         in_buf_d  = bus.net_di;
         in_full_d = 1'b1;
      end

      // A write while full (including the draining cycle) is dropped.
      if (bus.net_so) begin
         out_full_d = 1'b0;
      end else if (wr_out && !out_full_q) begin
         out_buf_d  = bus.d_in;
         out_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_buf_q   <= '0;
         out_buf_q  <= '0;
         d_out_q    <= '0;
         in_full_q  <= 1'b0;
         out_full_q <= 1'b0;
      end else begin
         in_buf_q   <= in_buf_d;
         out_buf_q  <= out_buf_d;
         d_out_q    <= d_out_d;
         in_full_q  <= in_full_d;
         out_full_q <= out_full_d;
      end
   end

endmodule
